// File: rtl/uart_param_recv.sv
// 8N1 UART receiver, LSB first, with two-flop input synchroniser and mid-bit sampling.
// Bit period is countOfStrobe+1 clock cycles, matching the companion transmitter.
module uart_param_recv #(
  parameter int unsigned countOfStrobe = 865
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_data_rdy,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int unsigned CntW = $clog2(countOfStrobe + 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(countOfStrobe / 2);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(countOfStrobe);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [3:0]      r_bitcnt, w_bitcnt_d;
  logic [7:0]      r_sh, w_sh_d;
  logic [7:0]      r_data, w_data_d;
  logic            r_data_rdy, w_data_rdy_d;
  logic            r_frame_err, w_frame_err_d;
  logic            r_rx_m, r_rx_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_bitcnt    <= '0;
      r_sh        <= '0;
      r_data      <= '0;
      r_data_rdy  <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_m      <= 1'b1;
      r_rx_s      <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_bitcnt    <= w_bitcnt_d;
      r_sh        <= w_sh_d;
      r_data      <= w_data_d;
      r_data_rdy  <= w_data_rdy_d;
      r_frame_err <= w_frame_err_d;
      r_rx_m      <= i_rx;
      r_rx_s      <= r_rx_m;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_bitcnt_d    = r_bitcnt;
    w_sh_d        = r_sh;
    w_data_d      = r_data;
    w_data_rdy_d  = 1'b0;
    w_frame_err_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!r_rx_s) begin
          w_state_d = StStart;
          w_cnt_d   = '0;
        end
      end
      StStart: begin
        if (r_cnt < HalfCnt) begin
          w_cnt_d = r_cnt + 1'b1;
        end else if (!r_rx_s) begin
          w_state_d  = StData;
          w_cnt_d    = '0;
          w_bitcnt_d = '0;
        end else begin
          // Low pulse too short to be a start bit.
          w_state_d = StIdle;
        end
      end
      StData: begin
        if (r_cnt < MaxCnt) begin
          w_cnt_d = r_cnt + 1'b1;
        end else begin
          w_sh_d     = {r_rx_s, r_sh[7:1]};
          w_cnt_d    = '0;
          w_bitcnt_d = r_bitcnt + 1'b1;
          if (r_bitcnt == 4'd7) begin
            w_state_d = StStop;
          end
        end
      end
      StStop: begin
        if (r_cnt < MaxCnt) begin
          w_cnt_d = r_cnt + 1'b1;
        end else if (r_rx_s) begin
          w_data_d     = r_sh;
          w_data_rdy_d = 1'b1;
          w_state_d    = StIdle;
        end else begin
          w_frame_err_d = 1'b1;
          w_state_d     = StBreak;
        end
      end
      StBreak: begin
        // Hold here while the line stays low so a break yields a single error.
        if (r_rx_s) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign o_data      = r_data;
  assign o_data_rdy  = r_data_rdy;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state != StIdle);

endmodule
